// File: rtl/locked_grant_pkg.sv
// Shared types and sizing helpers for the locked-grant packet multiplexer.
package locked_grant_pkg;

    localparam int DEF_N       = 8;
    localparam int DEF_W       = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } lg_state_e;

    // Index width never collapses to zero, so a single-source build still has a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary index encoder; an all-zero input encodes as 0.
module onehot_to_bin #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | IW'(i);
            end
        end
    end

endmodule

// File: rtl/locked_grant_mux.sv
// Packet-level N:1 valid/ready mux: locks the lowest-index requester until its last beat.
// Optional stall watchdog is compiled in with LOCKED_GRANT_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no grant held; arbitrate among pending requests this cycle
// LOCK  | grant held; steer granted source to the output until its last handshake
module locked_grant_mux
    import locked_grant_pkg::*;
#(
    parameter  int N       = DEF_N,
    parameter  int W       = DEF_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int IW      = idx_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic [N-1:0]   grant,
    output logic [IW-1:0]  grant_idx,
    output logic           busy
`ifdef LOCKED_GRANT_WATCHDOG_EN
    ,
    output logic           timeout_err
`endif
);

    if (N < 1) begin : g_bad_n
        $error("locked_grant_mux: N must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("locked_grant_mux: TIMEOUT must be at least 1");
    end

    lg_state_e      state;
    logic [N-1:0]   pick;
    logic           granted_req;
    logic           stall_hit;
    logic           beat_xfer;
    logic           pkt_done;
    logic [W-1:0]   data_mux;
    logic           last_mux;

    // Lowest set bit of the pending requests.
    assign pick = req & ~(req - N'(1));

    assign granted_req = |(req & grant);

    onehot_to_bin #(
        .N  (N),
        .IW (IW)
    ) u_grant_enc (
        .onehot (grant),
        .idx    (grant_idx)
    );

    always_comb begin
        data_mux = '0;
        last_mux = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                data_mux = data_mux | in_data[i*W +: W];
                last_mux = last_mux | in_last[i];
            end
        end
    end

    assign out_data = data_mux;
    assign out_last = last_mux;
    assign busy     = (state == LOCK);

    // A grant being revoked by the watchdog must not also complete a beat.
    assign out_valid = busy & granted_req & ~stall_hit;
    assign in_ready  = (busy && !stall_hit) ? (grant & {N{out_ready}}) : '0;

    assign beat_xfer = out_valid & out_ready;
    assign pkt_done  = beat_xfer & out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= pick;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (pkt_done || stall_hit) begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOCKED_GRANT_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt;

    assign stall_hit   = (stall_cnt == CNT_W'(TIMEOUT));
    assign timeout_err = stall_hit;

    // Counts only cycles where the granted source has nothing to offer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!busy || stall_hit || beat_xfer) begin
            stall_cnt <= '0;
        end else if (!granted_req) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

endmodule

// File: tb/tb_locked_grant_mux.sv
// Self-checking bench for locked_grant_mux: directed scenarios plus randomized traffic
// compared every cycle against a source-index reference model.
module tb_locked_grant_mux;

    localparam int N       = 8;
    localparam int W       = 32;
    localparam int TIMEOUT = 16;
    localparam int IW      = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic [IW-1:0]  grant_idx;
    logic           busy;
`ifdef LOCKED_GRANT_WATCHDOG_EN
    logic           timeout_err;
`endif

    locked_grant_mux #(
        .N       (N),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .busy        (busy)
`ifdef LOCKED_GRANT_WATCHDOG_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which source owns the output (-1 = none) and stall cycles seen.
    int locked = -1;
    int stall  = 0;
    int last_hs = -1;
    int beats_left [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic [W-1:0] ed;
        logic         ev;
        logic         el;
        logic         to;
        bit           found;
        #1;
        to = 1'b0;
`ifdef LOCKED_GRANT_WATCHDOG_EN
        to = (locked >= 0) && (stall == TIMEOUT);
`endif
        eg = (locked >= 0) ? (N'(1) << locked) : '0;
        ev = (locked >= 0) && req[locked] && !to;
        ed = (locked >= 0) ? in_data[locked*W +: W] : '0;
        el = (locked >= 0) ? in_last[locked] : 1'b0;
        er = ((locked >= 0) && out_ready && !to) ? eg : '0;
        chk("grant", grant, eg);
        chk("grant_idx", grant_idx, (locked >= 0) ? locked : 0);
        chk("busy", busy, locked >= 0);
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data, ed);
        chk("out_last", out_last, el);
        chk("in_ready", in_ready, er);
`ifdef LOCKED_GRANT_WATCHDOG_EN
        chk("timeout_err", timeout_err, to);
`endif
        last_hs = (ev && out_ready) ? locked : -1;
        @(posedge clk);
        if (locked < 0) begin
            stall = 0;
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (req[i] && !found) begin
                    locked = i;
                    found  = 1;
                end
            end
        end else if (to) begin
            locked = -1;
            stall  = 0;
        end else if (last_hs >= 0) begin
            stall = 0;
            if (in_last[locked]) locked = -1;
        end else if (!req[locked]) begin
            stall++;
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL bench_timeout: simulation did not finish, limit 300000");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cycle();

        // Priority pick and 3-beat packet from source 2, then bubble and source 3.
        req = 8'b0010_1100;
        in_data[2*W +: W] = 32'hA0;
        in_data[3*W +: W] = 32'h30;
        in_data[5*W +: W] = 32'h50;
        cycle();
        chk("pick_grant", grant, 8'b0000_0100);
        chk("pick_idx", grant_idx, 2);
        for (int b = 0; b < 3; b++) begin
            in_data[2*W +: W] = 32'hA0 + 32'(b);
            in_last[2] = (b == 2);
            cycle();
        end
        req[2] = 1'b0;
        in_last[2] = 1'b0;
        chk("bubble_busy", busy, 0);
        cycle();
        chk("next_idx", grant_idx, 3);
        in_last[3] = 1'b1;
        cycle();
        req[3] = 1'b0;
        in_last[3] = 1'b0;
        cycle();
        chk("src5_idx", grant_idx, 5);

        // Source 0 raises mid-packet; source 5 keeps the lock.
        cycle();
        req[0] = 1'b1;
        in_data[0] = 32'hB0;
        cycle();
        chk("hold_idx", grant_idx, 5);
        in_last[5] = 1'b1;
        cycle();
        req[5] = 1'b0;
        in_last[5] = 1'b0;
        chk("release_busy", busy, 0);
        cycle();
        chk("src0_idx", grant_idx, 0);
        chk("src0_busy", busy, 1);

        // Backpressure on beat 0xB0.
        in_data[0 +: W] = 32'hB0;
        in_last[0] = 1'b1;
        out_ready = 1'b0;
        repeat (4) begin
            cycle();
            chk("bp_data", out_data, 32'hB0);
            chk("bp_ready", in_ready, 0);
            chk("bp_hold", grant, 8'b0000_0001);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_xfer", last_hs, 0);
        req = '0;
        in_last = '0;
        chk("bp_release", busy, 0);
        cycle();

        // Reset mid-packet.
        req = 8'b0000_0010;
        in_data[1*W +: W] = 32'hC0;
        cycle();
        cycle();
        in_data[1*W +: W] = 32'hC1;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_busy", busy, 0);
        locked = -1;
        stall  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'b1000_0000;
        in_data[7*W +: W] = 32'h70;
        cycle();
        chk("post_rst_idx", grant_idx, 7);
        in_last[7] = 1'b1;
        cycle();
        req = '0;
        in_last = '0;
        cycle();

        // Granted source goes silent.
        req = 8'b0000_1000;
        cycle();
        req = '0;
`ifdef LOCKED_GRANT_WATCHDOG_EN
        repeat (TIMEOUT) cycle();
        chk("wd_pulse", timeout_err, 1);
        cycle();
        chk("wd_release", grant, 0);
        chk("wd_pulse_end", timeout_err, 0);
`else
        repeat (100) cycle();
        chk("hold_100", grant, 8'b0000_1000);
        req[3] = 1'b1;
        in_last[3] = 1'b1;
        cycle();
        req = '0;
        in_last = '0;
`endif
        cycle();

        // Randomized traffic; req only drops right after a completed handshake.
        for (int i = 0; i < N; i++) beats_left[i] = 0;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 4 == 0)) begin
                    req[i] = 1'b1;
                    if (beats_left[i] == 0) beats_left[i] = 1 + int'($urandom % 4);
                    in_data[i*W +: W] = $urandom;
                    in_last[i] = (beats_left[i] == 1);
                end
            end
            out_ready = ($urandom % 4 != 0);
            cycle();
            if (last_hs >= 0) begin
                beats_left[last_hs]--;
                in_data[last_hs*W +: W] = $urandom;
                if (beats_left[last_hs] == 0) begin
                    if ($urandom % 2 == 0) begin
                        req[last_hs] = 1'b0;
                    end else begin
                        beats_left[last_hs] = 1 + int'($urandom % 4);
                    end
                end else if ($urandom % 3 == 0) begin
                    req[last_hs] = 1'b0;
                end
                in_last[last_hs] = (beats_left[last_hs] == 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
